// File: rtl/mem_pkg.sv
// Shared constants and the lane-merge helper for the byte-enable RAM family.
package mem_pkg;

    localparam int RDW_OLD      = 0;
    localparam int RDW_NEW      = 1;
    localparam int OUT_REG_NONE = 0;
    localparam int OUT_REG_ON   = 1;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_DW = 256;

    function automatic logic [MAX_DW-1:0] byte_merge(
        input logic [MAX_DW-1:0] old_w,
        input logic [MAX_DW-1:0] new_w,
        input logic [MAX_DW-1:0] be,
        input int                byte_w
    );
        logic [MAX_DW-1:0] res;
        res = old_w;
        for (int b = 0; b < MAX_DW; b++) begin
            if (be[b / byte_w]) begin
                res[b] = new_w[b];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ram_sdp_be_fwd.sv
// Read-during-write forwarding: remembers a same-address write seen with a
// read and overlays its enabled lanes onto the array's old word.
module ram_sdp_be_fwd
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8,
    parameter int NUM_BYTES  = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  re_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] read_addr_i,
    input  logic [ADDR_WIDTH-1:0] write_addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [NUM_BYTES-1:0]  be_i,
    input  logic [DATA_WIDTH-1:0] rd_word_i,
    output logic [DATA_WIDTH-1:0] word_o
);

    logic                  hit_q, hit_d;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NUM_BYTES-1:0]  be_q;

    assign hit_d = we_i && (read_addr_i == write_addr_i);

    // Only a new read refreshes the capture, so the merged word holds with q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_q   <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (re_i) begin
            hit_q   <= hit_d;
            wdata_q <= data_i;
            be_q    <= be_i;
        end
    end

    always_comb begin
        word_o = rd_word_i;
        if (hit_q) begin
            word_o = DATA_WIDTH'(byte_merge(MAX_DW'(rd_word_i), MAX_DW'(wdata_q),
                                            MAX_DW'(be_q), BYTE_WIDTH));
        end
    end

endmodule

// File: rtl/ram_sdp_be.sv
// Simple dual-port RAM with byte-lane writes, read enable with output hold,
// selectable read-during-write behaviour and an optional output register.
module ram_sdp_be
    import mem_pkg::*;
#(
    parameter int    DATA_WIDTH = 32,
    parameter int    ADDR_WIDTH = 8,
    parameter int    BYTE_WIDTH = 8,
    parameter int    OUT_REG    = 0,
    parameter int    RDW_MODE   = 0,
    parameter string INIT_FILE  = ""
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [DATA_WIDTH-1:0]              data,
    input  logic [ADDR_WIDTH-1:0]              write_addr,
    input  logic                               we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be,
    input  logic [ADDR_WIDTH-1:0]              read_addr,
    input  logic                               re,
    output logic [DATA_WIDTH-1:0]              q,
    output logic                               q_valid
);

    localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH     = 2 ** ADDR_WIDTH;

    if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
        $error("ram_sdp_be: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
        $error("ram_sdp_be: RDW_MODE must be 0 or 1");
    end
    if (OUT_REG != OUT_REG_NONE && OUT_REG != OUT_REG_ON) begin : g_bad_oreg
        $error("ram_sdp_be: OUT_REG must be 0 or 1");
    end
    if (DATA_WIDTH > MAX_DW) begin : g_bad_max
        $error("ram_sdp_be: DATA_WIDTH exceeds mem_pkg::MAX_DW");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst && we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (be[i]) begin
                    mem[write_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Non-blocking array read returns the pre-write word on a collision.
    logic [DATA_WIDTH-1:0] rd_word_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_word_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= re;
            if (re) begin
                rd_word_q <= mem[read_addr];
            end
        end
    end

    logic [DATA_WIDTH-1:0] stage1_word;

    if (RDW_MODE == RDW_NEW) begin : g_fwd
        ram_sdp_be_fwd #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .BYTE_WIDTH (BYTE_WIDTH),
            .NUM_BYTES  (NUM_BYTES)
        ) u_fwd (
            .clk_i        (clk),
            .rst_i        (rst),
            .re_i         (re),
            .we_i         (we),
            .read_addr_i  (read_addr),
            .write_addr_i (write_addr),
            .data_i       (data),
            .be_i         (be),
            .rd_word_i    (rd_word_q),
            .word_o       (stage1_word)
        );
    end else begin : g_nofwd
        assign stage1_word = rd_word_q;
    end

    if (OUT_REG == OUT_REG_ON) begin : g_oreg
        logic [DATA_WIDTH-1:0] q_q;
        logic                  q_valid_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                q_q       <= '0;
                q_valid_q <= 1'b0;
            end else begin
                q_valid_q <= rd_valid_q;
                if (rd_valid_q) begin
                    q_q <= stage1_word;
                end
            end
        end

        assign q       = q_q;
        assign q_valid = q_valid_q;
    end else begin : g_noreg
        assign q       = stage1_word;
        assign q_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_ram_sdp_be.sv
// Directed bench for ram_sdp_be: four parameterisations share one stimulus bus.
module tb_ram_sdp_be;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic        re;
    logic [3:0]  be;
    logic [7:0]  waddr;
    logic [7:0]  raddr;
    logic [31:0] wdata;

    logic [31:0] q_a, q_b, q_c, q_d;
    logic        v_a, v_b, v_c, v_d;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // a: latency 1, old data; b: latency 1, new data; c: latency 2, new data; d: 16 words
    ram_sdp_be #(.OUT_REG(0), .RDW_MODE(0)) u_a (
        .clk(clk), .rst(rst), .data(wdata), .write_addr(waddr), .we(we), .be(be),
        .read_addr(raddr), .re(re), .q(q_a), .q_valid(v_a));
    ram_sdp_be #(.OUT_REG(0), .RDW_MODE(1)) u_b (
        .clk(clk), .rst(rst), .data(wdata), .write_addr(waddr), .we(we), .be(be),
        .read_addr(raddr), .re(re), .q(q_b), .q_valid(v_b));
    ram_sdp_be #(.OUT_REG(1), .RDW_MODE(1)) u_c (
        .clk(clk), .rst(rst), .data(wdata), .write_addr(waddr), .we(we), .be(be),
        .read_addr(raddr), .re(re), .q(q_c), .q_valid(v_c));
    ram_sdp_be #(.ADDR_WIDTH(4), .OUT_REG(0), .RDW_MODE(0)) u_d (
        .clk(clk), .rst(rst), .data(wdata), .write_addr(waddr[3:0]), .we(we), .be(be),
        .read_addr(raddr[3:0]), .re(re), .q(q_d), .q_valid(v_d));

    typedef struct {
        logic        rst;
        logic        we;
        logic [3:0]  be;
        logic [7:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [7:0]  ra;
        logic [31:0] qa;
        logic        va;
        logic [31:0] qb;
        logic        vb;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic w, input logic [3:0] b,
                        input logic [7:0] a_w, input logic [31:0] d,
                        input logic rd, input logic [7:0] a_r);
        rst   = r;
        we    = w;
        be    = b;
        waddr = a_w;
        wdata = d;
        re    = rd;
        raddr = a_r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; be = '0; waddr = '0; raddr = '0; wdata = '0;

        //          rst   we    be    wa     wd            re    ra     qa            va    qb            vb
        vecs[0]  = '{1'b1, 1'b0, 4'h0, 8'h00, 32'h00000000, 1'b0, 8'h00, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 4'hF, 8'h05, 32'hAABBCCDD, 1'b0, 8'h00, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 4'h5, 8'h05, 32'h11223344, 1'b0, 8'h00, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h05, 32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h00000000, 1'b0, 8'h00, 32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 4'hF, 8'h03, 32'h00000000, 1'b0, 8'h00, 32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 4'hF, 8'h03, 32'hDEADBEEF, 1'b1, 8'h03, 32'h00000000, 1'b1, 32'hDEADBEEF, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h03, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 4'hF, 8'h03, 32'h12345678, 1'b0, 8'h00, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 4'h8, 8'h03, 32'hFF000000, 1'b1, 8'h03, 32'h12345678, 1'b1, 32'hFF345678, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h00000000, 1'b0, 8'h00, 32'h12345678, 1'b0, 32'hFF345678, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h03, 32'hFF345678, 1'b1, 32'hFF345678, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 4'hF, 8'h07, 32'h01020304, 1'b1, 8'h05, 32'hAA22CC44, 1'b1, 32'hAA22CC44, 1'b1};
        vecs[13] = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h07, 32'h01020304, 1'b1, 32'h01020304, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 4'h0, 8'h07, 32'hFFFFFFFF, 1'b1, 8'h07, 32'h01020304, 1'b1, 32'h01020304, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h07, 32'h01020304, 1'b1, 32'h01020304, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 4'hF, 8'h07, 32'hBAD0BAD0, 1'b1, 8'h07, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 4'h0, 8'h00, 32'h00000000, 1'b1, 8'h07, 32'h01020304, 1'b1, 32'h01020304, 1'b1};

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].we, vecs[i].be, vecs[i].wa, vecs[i].wd, vecs[i].re, vecs[i].ra);
            chk($sformatf("row%0d q_a", i), q_a, vecs[i].qa);
            chk($sformatf("row%0d v_a", i), {31'b0, v_a}, {31'b0, vecs[i].va});
            chk($sformatf("row%0d q_b", i), q_b, vecs[i].qb);
            chk($sformatf("row%0d v_b", i), {31'b0, v_b}, {31'b0, vecs[i].vb});
        end

        // Two-stage streaming: three back-to-back reads, then hold.
        step(1'b0, 1'b1, 4'hF, 8'h00, 32'h00000100, 1'b0, 8'h00);
        step(1'b0, 1'b1, 4'hF, 8'h01, 32'h00000101, 1'b0, 8'h00);
        step(1'b0, 1'b1, 4'hF, 8'h02, 32'h00000102, 1'b0, 8'h00);
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00);
        chk("stream e1 v_c", {31'b0, v_c}, 32'd0);
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h01);
        chk("stream e2 q_c", q_c, 32'h00000100);
        chk("stream e2 v_c", {31'b0, v_c}, 32'd1);
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h02);
        chk("stream e3 q_c", q_c, 32'h00000101);
        chk("stream e3 v_c", {31'b0, v_c}, 32'd1);
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        chk("stream e4 q_c", q_c, 32'h00000102);
        chk("stream e4 v_c", {31'b0, v_c}, 32'd1);
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        chk("stream hold q_c", q_c, 32'h00000102);
        chk("stream hold v_c", {31'b0, v_c}, 32'd0);

        // Reset lands while a read is in the pipe; a write under reset is dropped.
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h01);
        step(1'b1, 1'b1, 4'hF, 8'h02, 32'hDEAD0000, 1'b0, 8'h00);
        chk("rst q_c", q_c, 32'h0);
        chk("rst v_c", {31'b0, v_c}, 32'd0);
        chk("rst q_a", q_a, 32'h0);
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        chk("post rst v_c 1", {31'b0, v_c}, 32'd0);
        chk("post rst q_c", q_c, 32'h0);
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        chk("post rst v_c 2", {31'b0, v_c}, 32'd0);
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h02);
        chk("readback s1 v_c", {31'b0, v_c}, 32'd0);
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0, 8'h00);
        chk("readback q_c", q_c, 32'h00000102);
        chk("readback v_c", {31'b0, v_c}, 32'd1);

        // 16-word instance: top and bottom words, and address wrap by width.
        step(1'b0, 1'b1, 4'hF, 8'h0F, 32'hCAFEF00D, 1'b0, 8'h00);
        step(1'b0, 1'b1, 4'hF, 8'h10, 32'h00000000, 1'b0, 8'h00);
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h0F);
        chk("wrap rd15 q_d", q_d, 32'hCAFEF00D);
        chk("wrap rd15 v_d", {31'b0, v_d}, 32'd1);
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h00);
        chk("wrap rd0 q_d", q_d, 32'h00000000);
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'hFF);
        chk("wrap rdFF q_d", q_d, 32'hCAFEF00D);
        step(1'b0, 1'b1, 4'hF, 8'h1F, 32'h12345678, 1'b1, 8'h0F);
        chk("wrap coll q_d", q_d, 32'hCAFEF00D);
        step(1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b1, 8'h0F);
        chk("wrap after q_d", q_d, 32'h12345678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
